// File: rtl/spram_stream_loader_if.sv
// Stream-in and spram write-port bundle for the stream loader.
// The loader is the slave; whoever feeds the stream and watches memory is the master.
interface spram_stream_loader_if #(
    parameter int c_ADDR_WIDTH = 10,
    parameter int c_DATA_WIDTH = 32,
    parameter int c_IN_WIDTH   = 8
);
    logic [c_IN_WIDTH-1:0]   s_data;
    logic                    s_valid;
    logic                    s_last;
    logic                    s_ready;
    logic [c_ADDR_WIDTH-1:0] mem_addr;
    logic [c_DATA_WIDTH-1:0] mem_wr_data;
    logic                    mem_wr_en;
    logic                    mem_clk_en;

    modport master (
        output s_data, s_valid, s_last,
        input  s_ready, mem_addr, mem_wr_data, mem_wr_en, mem_clk_en
    );

    modport slave (
        input  s_data, s_valid, s_last,
        output s_ready, mem_addr, mem_wr_data, mem_wr_en, mem_clk_en
    );
endinterface

// File: rtl/spram_stream_loader.sv
// Packs a narrow valid/ready stream little-endian into spram words and writes
// them sequentially from address 0, one write cycle per completed word.
module spram_stream_loader #(
    parameter int c_ADDR_WIDTH = 10,
    parameter int c_DATA_WIDTH = 32,
    parameter int c_IN_WIDTH   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    spram_stream_loader_if.slave    bus,
    output logic                    busy,
    output logic                    done,
    output logic                    full,
    output logic [c_ADDR_WIDTH:0]   words_written
);
    localparam int c_BEATS = c_DATA_WIDTH / c_IN_WIDTH;
    localparam int c_IDX_W = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    localparam logic [c_IDX_W-1:0]    c_IDX_LAST  = c_IDX_W'(c_BEATS - 1);
    localparam logic [c_ADDR_WIDTH:0] c_LAST_WORD = {1'b0, {c_ADDR_WIDTH{1'b1}}};

    if (c_DATA_WIDTH % c_IN_WIDTH != 0) begin : g_width_check
        $error("c_DATA_WIDTH must be an integer multiple of c_IN_WIDTH");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [c_DATA_WIDTH-1:0] pack_q, pack_d;
    logic [c_IDX_W-1:0]      idx_q, idx_d;
    logic [c_ADDR_WIDTH:0]   words_q, words_d;
    logic                    full_q, full_d;
    logic [c_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [c_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                    wr_en_q, wr_en_d;
    logic [c_DATA_WIDTH-1:0] merged;

    // words_q doubles as the write pointer: it only ever counts completed writes.
    always_comb begin
        state_d = state_q;
        pack_d  = pack_q;
        idx_d   = idx_q;
        words_d = words_q;
        full_d  = full_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_en_d = 1'b0;
        merged  = pack_q;
        merged[idx_q*c_IN_WIDTH +: c_IN_WIDTH] = bus.s_data;

        case (state_q)
            ST_LOAD: begin
                if (bus.s_valid) begin
                    if (idx_q == c_IDX_LAST || bus.s_last) begin
                        wr_en_d = 1'b1;
                        wdata_d = merged;
                        addr_d  = words_q[c_ADDR_WIDTH-1:0];
                        words_d = words_q + (c_ADDR_WIDTH+1)'(1);
                        pack_d  = '0;
                        idx_d   = '0;
                        if (bus.s_last) begin
                            state_d = ST_DONE;
                        end else if (words_q == c_LAST_WORD) begin
                            state_d = ST_DONE;
                            full_d  = 1'b1;
                        end
                    end else begin
                        pack_d = merged;
                        idx_d  = idx_q + c_IDX_W'(1);
                    end
                end
            end
            default: begin
                if (start) begin
                    state_d = ST_LOAD;
                    pack_d  = '0;
                    idx_d   = '0;
                    words_d = '0;
                    full_d  = 1'b0;
                    addr_d  = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pack_q  <= '0;
            idx_q   <= '0;
            words_q <= '0;
            full_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pack_q  <= pack_d;
            idx_q   <= idx_d;
            words_q <= words_d;
            full_q  <= full_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_en_q <= wr_en_d;
        end
    end

    assign bus.s_ready     = (state_q == ST_LOAD);
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wr_data = wdata_q;
    assign bus.mem_wr_en   = wr_en_q;
    assign bus.mem_clk_en  = (state_q == ST_LOAD) || wr_en_q;
    assign busy            = (state_q == ST_LOAD);
    assign done            = (state_q == ST_DONE);
    assign full            = full_q;
    assign words_written   = words_q;
endmodule

// File: tb/tb_spram_stream_loader.sv
// Bench for spram_stream_loader: a default-size loader (a) and a 4-word loader (b)
// share one stream; a behavioural model is compared every cycle, plus literal word checks.
module tb_spram_stream_loader;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic s_valid = 1'b0;
    logic s_last = 1'b0;

    logic busy_a, done_a, full_a, busy_b, done_b, full_b;
    logic [10:0] ww_a;
    logic [2:0]  ww_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_b = 0;

    spram_stream_loader_if #(.c_ADDR_WIDTH(10)) ifa ();
    spram_stream_loader_if #(.c_ADDR_WIDTH(2))  ifb ();

    assign ifa.s_data  = s_data;
    assign ifa.s_valid = s_valid;
    assign ifa.s_last  = s_last;
    assign ifb.s_data  = s_data;
    assign ifb.s_valid = s_valid;
    assign ifb.s_last  = s_last;

    spram_stream_loader #(.c_ADDR_WIDTH(10)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .bus(ifa),
        .busy(busy_a), .done(done_a), .full(full_a), .words_written(ww_a)
    );

    spram_stream_loader #(.c_ADDR_WIDTH(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .bus(ifb),
        .busy(busy_b), .done(done_b), .full(full_b), .words_written(ww_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: phase 0 idle, 1 loading, 2 finished; bytes accumulate into a word value.
    int          m_cap[2] = '{1024, 4};
    int          m_phase[2];
    int          m_cnt[2];
    int          m_words[2];
    int          m_addr[2];
    bit          m_full[2];
    bit          m_wr[2];
    logic [31:0] m_acc[2];
    logic [31:0] m_wdata[2];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            m_wr[d] = 1'b0;
            if (!rst) begin
                m_phase[d] = 0; m_cnt[d] = 0; m_words[d] = 0; m_addr[d] = 0;
                m_full[d] = 1'b0; m_acc[d] = 32'h0;
            end else if (m_phase[d] == 1) begin
                if (s_valid) begin
                    m_acc[d] = m_acc[d] | (32'(s_data) << (8 * m_cnt[d]));
                    m_cnt[d] = m_cnt[d] + 1;
                    if (m_cnt[d] == 4 || s_last) begin
                        m_wr[d] = 1'b1;
                        m_wdata[d] = m_acc[d];
                        m_addr[d] = m_words[d];
                        m_words[d] = m_words[d] + 1;
                        m_acc[d] = 32'h0;
                        m_cnt[d] = 0;
                        if (s_last) m_phase[d] = 2;
                        else if (m_words[d] == m_cap[d]) begin
                            m_full[d] = 1'b1;
                            m_phase[d] = 2;
                        end
                    end
                end
            end else if ((d == 0) ? start_a : start_b) begin
                m_phase[d] = 1; m_cnt[d] = 0; m_words[d] = 0; m_addr[d] = 0;
                m_full[d] = 1'b0; m_acc[d] = 32'h0;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cmp(input int d, input logic rdy, input logic bsy, input logic dn,
                       input logic fl, input logic wen, input logic cen,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [63:0] words);
        string p;
        p = (d == 0) ? "a" : "b";
        chk({p, "_s_ready"}, 64'(rdy), 64'(m_phase[d] == 1));
        chk({p, "_busy"}, 64'(bsy), 64'(m_phase[d] == 1));
        chk({p, "_done"}, 64'(dn), 64'(m_phase[d] == 2));
        chk({p, "_full"}, 64'(fl), 64'(m_full[d]));
        chk({p, "_wr_en"}, 64'(wen), 64'(m_wr[d]));
        chk({p, "_clk_en"}, 64'(cen), 64'(m_phase[d] == 1 || m_wr[d]));
        chk({p, "_addr"}, addr, 64'(m_addr[d]));
        chk({p, "_words"}, words, 64'(m_words[d]));
        if (m_wr[d]) chk({p, "_wr_data"}, wdata, 64'(m_wdata[d]));
    endtask

    int          la_addr[$];
    logic [31:0] la_data[$];
    int          la_cyc[$];
    int          lb_addr[$];
    logic [31:0] lb_data[$];

    always @(negedge clk) begin
        cmp(0, ifa.s_ready, busy_a, done_a, full_a, ifa.mem_wr_en, ifa.mem_clk_en,
            64'(ifa.mem_addr), 64'(ifa.mem_wr_data), 64'(ww_a));
        cmp(1, ifb.s_ready, busy_b, done_b, full_b, ifb.mem_wr_en, ifb.mem_clk_en,
            64'(ifb.mem_addr), 64'(ifb.mem_wr_data), 64'(ww_b));
        if (ifa.mem_wr_en === 1'b1) begin
            la_addr.push_back(int'(ifa.mem_addr));
            la_data.push_back(ifa.mem_wr_data);
            la_cyc.push_back(cyc);
        end
        if (ifb.mem_wr_en === 1'b1) begin
            lb_addr.push_back(int'(ifb.mem_addr));
            lb_data.push_back(ifb.mem_wr_data);
        end
        if (s_valid && ifb.s_ready === 1'b1) acc_b++;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] d, input bit last);
        s_data = d; s_last = last; s_valid = 1'b1;
        tick();
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic pulse_start(input bit which_b);
        if (which_b) start_b = 1'b1; else start_a = 1'b1;
        tick();
        start_a = 1'b0; start_b = 1'b0;
    endtask

    task automatic clear_logs();
        la_addr.delete(); la_data.delete(); la_cyc.delete();
        lb_addr.delete(); lb_data.delete();
    endtask

    int c4, c8;

    initial begin
        // Reset state
        tick(3);
        chk("rst_wr_data", 64'(ifa.mem_wr_data), 64'h0);
        chk("rst_words", 64'(ww_a), 64'h0);
        rst = 1'b1;
        tick();

        // Two full words, s_last on the 8th beat
        clear_logs();
        pulse_start(1'b0);
        for (int i = 0; i < 8; i++) begin
            send(8'(8'h11 * (i + 1)), i == 7);
            if (i == 3) c4 = cyc;
            if (i == 7) c8 = cyc;
        end
        tick(2);
        chk("t1_nwr", 64'(la_addr.size()), 64'd2);
        chk("t1_addr0", 64'(la_addr[0]), 64'd0);
        chk("t1_data0", 64'(la_data[0]), 64'h44332211);
        chk("t1_addr1", 64'(la_addr[1]), 64'd1);
        chk("t1_data1", 64'(la_data[1]), 64'h88776655);
        chk("t1_lat0", 64'(la_cyc[0]), 64'(c4));
        chk("t1_lat1", 64'(la_cyc[1]), 64'(c8));
        chk("t1_done", 64'(done_a), 64'd1);
        chk("t1_words", 64'(ww_a), 64'd2);
        chk("t1_full", 64'(full_a), 64'd0);

        // Partial final word is zero-padded
        clear_logs();
        pulse_start(1'b0);
        for (int i = 0; i < 6; i++) send(8'(8'hA0 + i), i == 5);
        tick(2);
        chk("t2_nwr", 64'(la_addr.size()), 64'd2);
        chk("t2_data0", 64'(la_data[0]), 64'hA3A2A1A0);
        chk("t2_data1", 64'(la_data[1]), 64'h0000A5A4);
        chk("t2_words", 64'(ww_a), 64'd2);

        // Valid gaps must not change packing
        clear_logs();
        pulse_start(1'b0);
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 1) == 1) tick();
            send(8'(8'h30 + i), i == 11);
        end
        tick(2);
        chk("t3_nwr", 64'(la_addr.size()), 64'd3);
        chk("t3_data0", 64'(la_data[0]), 64'h33323130);
        chk("t3_data1", 64'(la_data[1]), 64'h37363534);
        chk("t3_data2", 64'(la_data[2]), 64'h3B3A3938);
        chk("t3_addr2", 64'(la_addr[2]), 64'd2);

        // Capacity reached on the 4-word loader
        clear_logs();
        acc_b = 0;
        pulse_start(1'b1);
        for (int i = 0; i < 20; i++) send(8'(i + 1), 1'b0);
        tick(2);
        chk("t4_nwr", 64'(lb_addr.size()), 64'd4);
        chk("t4_data0", 64'(lb_data[0]), 64'h04030201);
        chk("t4_data3", 64'(lb_data[3]), 64'h100F0E0D);
        chk("t4_addr3", 64'(lb_addr[3]), 64'd3);
        chk("t4_full", 64'(full_b), 64'd1);
        chk("t4_words", 64'(ww_b), 64'd4);
        chk("t4_ready", 64'(ifb.s_ready), 64'd0);
        chk("t4_accepted", 64'(acc_b), 64'd16);
        chk("t4_a_quiet", 64'(la_addr.size()), 64'd0);

        // Reset mid-word, together with a completing beat and a start
        clear_logs();
        pulse_start(1'b0);
        for (int i = 0; i < 3; i++) send(8'(8'h51 + i), 1'b0);
        s_data = 8'h54; s_valid = 1'b1; start_a = 1'b1; rst = 1'b0;
        tick();
        s_valid = 1'b0; start_a = 1'b0;
        chk("t5_busy", 64'(busy_a), 64'd0);
        chk("t5_ready", 64'(ifa.s_ready), 64'd0);
        chk("t5_wr_en", 64'(ifa.mem_wr_en), 64'd0);
        chk("t5_clk_en", 64'(ifa.mem_clk_en), 64'd0);
        chk("t5_addr", 64'(ifa.mem_addr), 64'd0);
        chk("t5_wr_data", 64'(ifa.mem_wr_data), 64'h0);
        chk("t5_b_full", 64'(full_b), 64'd0);
        rst = 1'b1;
        tick(2);
        chk("t5_nowr", 64'(la_addr.size()), 64'd0);
        pulse_start(1'b0);
        for (int i = 0; i < 4; i++) send(8'(8'hC1 + i), i == 3);
        tick(2);
        chk("t5_nwr", 64'(la_addr.size()), 64'd1);
        chk("t5_data", 64'(la_data[0]), 64'hC4C3C2C1);
        chk("t5_words", 64'(ww_a), 64'd1);

        // Restart from DONE; start during LOAD is ignored
        clear_logs();
        pulse_start(1'b0);
        chk("t6_done_clr", 64'(done_a), 64'd0);
        chk("t6_busy", 64'(busy_a), 64'd1);
        send(8'hD1, 1'b0);
        send(8'hD2, 1'b0);
        start_a = 1'b1;
        send(8'hD3, 1'b0);
        start_a = 1'b0;
        send(8'hD4, 1'b1);
        tick(2);
        chk("t6_nwr", 64'(la_addr.size()), 64'd1);
        chk("t6_addr", 64'(la_addr[0]), 64'd0);
        chk("t6_data", 64'(la_data[0]), 64'hD4D3D2D1);
        chk("t6_words", 64'(ww_a), 64'd1);
        chk("t6_done", 64'(done_a), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
